temp_sample_ctrl: RTL

//  Sequencer for the PT100 temperature path: periodically triggers the external ADC, accumulates
//  2^AVG_LOG2 conversions, and presents the averaged 10-bit code to the combinational pt100

---
 rtl/temp_sample_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/temp_sample_ctrl.sv
// PT100 sample sequencer: periodic ADC triggering, 2^AVG_LOG2 averaging,
// registered temperature with valid strobe, hysteretic alarm, sticky ADC timeout.
module temp_sample_ctrl #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned HYST     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic       adc_start_o,
  input  logic       adc_done_i,
  input  logic [9:0] adc_data_i,
  output logic [9:0] avg_o,
  input  logic [7:0] temp_i,
  input  logic [7:0] thresh_i,
  output logic [7:0] temp_o,
  output logic       temp_valid_o,
  output logic       alarm_o,
  output logic       timeout_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned ACC_W = 10 + AVG_LOG2;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_AVG   = 3'd3,
    S_CONV  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [9:0]         avg_q, avg_d;
  logic [7:0]         temp_q, temp_d;
  logic               alarm_q, alarm_d;
  logic               timeout_q, timeout_d;
  logic               start_q, start_d;
  logic               valid_q, valid_d;

  logic               tick;
  logic               last_sample;
  logic               wd_expire;
  logic [8:0]         temp_hyst;

  assign tick        = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign last_sample = (n_q == N_W'(NSAMP - 1));
  // Watchdog counts completed WAIT cycles; expiry is on the TIMEOUT-th one.
  assign wd_expire   = (wd_q == WD_W'(TIMEOUT - 1));
  // Widened so temp_i + HYST cannot wrap.
  assign temp_hyst   = {1'b0, temp_i} + 9'(HYST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; disabling forces IDLE from anywhere
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (tick) state_d = S_START;
        S_START: state_d = S_WAIT;
        S_WAIT: begin
          if (adc_done_i) begin
            state_d = last_sample ? S_AVG : S_START;
          end else if (wd_expire) begin
            state_d = S_IDLE;
          end
        end
        S_AVG:   state_d = S_CONV;
        S_CONV:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values decoded from the FSM
  always_comb begin
    cnt_d     = en_i ? (tick ? '0 : cnt_q + CNT_W'(1)) : '0;
    wd_d      = wd_q;
    n_d       = n_q;
    acc_d     = acc_q;
    avg_d     = avg_q;
    temp_d    = temp_q;
    alarm_d   = alarm_q;
    timeout_d = timeout_q;
    start_d   = (state_d == S_START);
    valid_d   = 1'b0;
    if (!en_i) begin
      acc_d = '0;
      n_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            acc_d = '0;
            n_d   = '0;
          end
        end
        S_START: wd_d = '0;
        S_WAIT: begin
          wd_d = wd_q + WD_W'(1);
          if (adc_done_i) begin
            acc_d = acc_q + ACC_W'(adc_data_i);
            n_d   = n_q + N_W'(1);
          end else if (wd_expire) begin
            timeout_d = 1'b1;
            acc_d     = '0;
            n_d       = '0;
          end
        end
        S_AVG: avg_d = 10'(acc_q >> AVG_LOG2);
        S_CONV: begin
          temp_d    = temp_i;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          if (temp_i >= thresh_i) begin
            alarm_d = 1'b1;
          end else if (temp_hyst < {1'b0, thresh_i}) begin
            alarm_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      wd_q      <= '0;
      n_q       <= '0;
      acc_q     <= '0;
      avg_q     <= '0;
      temp_q    <= '0;
      alarm_q   <= 1'b0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      n_q       <= n_d;
      acc_q     <= acc_d;
      avg_q     <= avg_d;
      temp_q    <= temp_d;
      alarm_q   <= alarm_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
    end
  end

  assign adc_start_o  = start_q;
  assign avg_o        = avg_q;
  assign temp_o       = temp_q;
  assign temp_valid_o = valid_q;
  assign alarm_o      = alarm_q;
  assign timeout_o    = timeout_q;

endmodule
